// File: rtl/pc_branch_unit_pkg.sv
// Shared defaults and branch-kind encoding for the next-PC / branch resolution logic.
package pc_branch_unit_pkg;
  localparam int WIDTH_DEF       = 64;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int IMM_SHIFT_DEF   = 2;
  localparam int CNT_WIDTH_DEF   = 32;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_COND   = 2'd1,
    BR_UNCOND = 2'd2,
    BR_REG    = 2'd3
  } br_kind_e;

  // When several kind flags are set, BR outranks B, which outranks CBZ/CBNZ.
  function automatic br_kind_e br_kind(input logic cond, input logic uncond, input logic reg_br);
    if (reg_br)      return BR_REG;
    else if (uncond) return BR_UNCOND;
    else if (cond)   return BR_COND;
    else             return BR_NONE;
  endfunction
endpackage

// File: rtl/pc_branch_unit_if.sv
// Execute-stage branch resolution bus: resolved instruction in, redirect/flush out.
interface pc_branch_unit_if
  import pc_branch_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             res_valid;
  logic [WIDTH-1:0] res_pc;
  logic [WIDTH-1:0] res_imm;
  logic [WIDTH-1:0] res_reg_target;
  logic             res_branch;
  logic             res_zero_invert;
  logic             res_uncond;
  logic             res_reg_branch;
  logic             res_alu_zero;
  logic             flush;
  logic             taken;

  modport master (
    output res_valid, res_pc, res_imm, res_reg_target, res_branch,
           res_zero_invert, res_uncond, res_reg_branch, res_alu_zero,
    input  flush, taken
  );

  modport slave (
    input  res_valid, res_pc, res_imm, res_reg_target, res_branch,
           res_zero_invert, res_uncond, res_reg_branch, res_alu_zero,
    output flush, taken
  );
endinterface

// File: rtl/pc_branch_unit_target_calc.sv
// Combinational branch resolution: taken decision, aligned target and misalignment flag.
module branch_target_calc
  import pc_branch_unit_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int IMM_SHIFT = IMM_SHIFT_DEF
) (
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [WIDTH-1:0] i_reg_target,
  input  logic             i_branch,
  input  logic             i_zero_invert,
  input  logic             i_uncond,
  input  logic             i_reg_branch,
  input  logic             i_alu_zero,
  output logic             o_is_br,
  output logic             o_taken,
  output logic [WIDTH-1:0] o_target,
  output logic             o_misalign
);
  br_kind_e         w_kind;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_low_mask;

  assign w_kind     = br_kind(i_branch, i_uncond, i_reg_branch);
  assign w_low_mask = (WIDTH'(1) << IMM_SHIFT) - WIDTH'(1);

  assign o_is_br = i_valid & (i_branch | i_uncond | i_reg_branch);
  assign o_taken = i_valid & (i_reg_branch | i_uncond |
                              (i_branch & (i_alu_zero ^ i_zero_invert)));

  // Offset is in instructions; adder wraps silently at 2^WIDTH.
  assign w_raw      = (w_kind == BR_REG) ? i_reg_target : i_pc + (i_imm << IMM_SHIFT);
  assign o_target   = w_raw & ~w_low_mask;
  assign o_misalign = o_taken & (|(w_raw & w_low_mask));
endmodule

// File: rtl/pc_branch_unit.sv
// Owns the fetch PC: sequential advance, stall hold, branch redirect, sticky misalign, branch stats.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter int               INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int               IMM_SHIFT   = IMM_SHIFT_DEF,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  pc_branch_unit_if.slave      bus,
  output logic [WIDTH-1:0]     o_pc,
  output logic                 o_misalign_fault,
  output logic [CNT_WIDTH-1:0] o_branch_count,
  output logic [CNT_WIDTH-1:0] o_taken_count
);
  logic                 w_is_br;
  logic                 w_taken;
  logic [WIDTH-1:0]     w_target;
  logic                 w_misalign;

  logic [WIDTH-1:0]     r_pc;
  logic                 r_fault;
  logic [CNT_WIDTH-1:0] r_bcnt;
  logic [CNT_WIDTH-1:0] r_tcnt;

  branch_target_calc #(.WIDTH(WIDTH), .IMM_SHIFT(IMM_SHIFT)) u_calc (
    .i_valid       (bus.res_valid),
    .i_pc          (bus.res_pc),
    .i_imm         (bus.res_imm),
    .i_reg_target  (bus.res_reg_target),
    .i_branch      (bus.res_branch),
    .i_zero_invert (bus.res_zero_invert),
    .i_uncond      (bus.res_uncond),
    .i_reg_branch  (bus.res_reg_branch),
    .i_alu_zero    (bus.res_alu_zero),
    .o_is_br       (w_is_br),
    .o_taken       (w_taken),
    .o_target      (w_target),
    .o_misalign    (w_misalign)
  );

  assign bus.flush = w_taken & ~i_rst;
  assign bus.taken = w_taken & ~i_rst;

  // Redirect beats stall: a resolved taken branch must never be lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_bcnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      if (w_taken)       r_pc <= w_target;
      else if (!i_stall) r_pc <= r_pc + WIDTH'(INSTR_BYTES);
      if (w_misalign) r_fault <= 1'b1;
      if (w_is_br && (r_bcnt != '1)) r_bcnt <= r_bcnt + CNT_WIDTH'(1);
      if (w_taken && (r_tcnt != '1)) r_tcnt <= r_tcnt + CNT_WIDTH'(1);
    end
  end

  assign o_pc             = r_pc;
  assign o_misalign_fault = r_fault;
  assign o_branch_count   = r_bcnt;
  assign o_taken_count    = r_tcnt;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed plus randomized check of pc_branch_unit against a behavioural next-PC model.
module tb_pc_branch_unit;
  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          CW     = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [63:0]   pc;
  logic          fault;
  logic [CW-1:0] bcnt, tcnt;

  pc_branch_unit_if #(.WIDTH(64)) bus ();

  pc_branch_unit #(.WIDTH(64), .INSTR_BYTES(4), .IMM_SHIFT(2), .RESET_PC(RST_PC), .CNT_WIDTH(CW)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .bus              (bus),
    .o_pc             (pc),
    .o_misalign_fault (fault),
    .o_branch_count   (bcnt),
    .o_taken_count    (tcnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [63:0] m_pc;
  logic        m_fault;
  int          m_bc, m_tc;
  int          cnt_max = (1 << CW) - 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic zi, input logic u, input logic rb,
                       input logic z, input logic [63:0] rpc, input logic [63:0] imm,
                       input logic [63:0] rt, input logic st);
    bus.res_valid = v;  bus.res_branch = b; bus.res_zero_invert = zi;
    bus.res_uncond = u; bus.res_reg_branch = rb; bus.res_alu_zero = z;
    bus.res_pc = rpc;   bus.res_imm = imm;   bus.res_reg_target = rt;
    stall = st;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, st);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_fault = 1'b0; m_bc = 0; m_tc = 0;
  endtask

  // Called after inputs are driven (just after a falling edge); ends at the next falling edge.
  task automatic cycle();
    logic        v, is_br, tk;
    logic [63:0] raw, tgt;
    v     = bus.res_valid;
    is_br = v && (bus.res_branch || bus.res_uncond || bus.res_reg_branch);
    if (!v)                                        tk = 1'b0;
    else if (bus.res_reg_branch || bus.res_uncond) tk = 1'b1;
    else if (bus.res_branch)  tk = bus.res_zero_invert ? !bus.res_alu_zero : bus.res_alu_zero;
    else                                           tk = 1'b0;
    raw = bus.res_reg_branch ? bus.res_reg_target : bus.res_pc + bus.res_imm * 64'd4;
    tgt = raw - (raw % 64'd4);
    #1;
    chk("flush", 64'(bus.flush), 64'(tk));
    chk("taken", 64'(bus.taken), 64'(tk));
    @(posedge clk);
    if (tk)          m_pc = tgt;
    else if (!stall) m_pc = m_pc + 64'd4;
    if (tk && (raw % 64'd4) != 0) m_fault = 1'b1;
    if (is_br && m_bc < cnt_max) m_bc++;
    if (tk && m_tc < cnt_max)    m_tc++;
    #1;
    chk("pc", pc, m_pc);
    chk("fault", 64'(fault), 64'(m_fault));
    chk("bcnt", 64'(bcnt), 64'(m_bc));
    chk("tcnt", 64'(tcnt), 64'(m_tc));
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_flush"}, 64'(bus.flush), 64'h0);
    chk({tag, "_taken"}, 64'(bus.taken), 64'h0);
    chk({tag, "_fault"}, 64'(fault), 64'h0);
    chk({tag, "_bcnt"}, 64'(bcnt), 64'h0);
    chk({tag, "_tcnt"}, 64'(tcnt), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);
    #1;
    model_reset();
    check_reset_state("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle(1'b0);
    model_reset();
    do_reset();

    // Sequential fetch from RESET_PC
    for (int i = 0; i < 3; i++) begin idle(1'b0); cycle(); end

    // B with negative offset: 0x2000 + (-4 << 2) = 0x1FF0
    drive(1, 0, 0, 1, 0, 0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0); cycle();

    // CBZ taken, CBNZ not taken, both ALUZero=1
    drive(1, 1, 0, 0, 0, 1, 64'h100, 64'd3, 64'h0, 0); cycle();
    drive(1, 1, 1, 0, 0, 1, 64'h100, 64'd3, 64'h0, 0); cycle();
    drive(1, 1, 1, 0, 0, 0, 64'h100, 64'd5, 64'h0, 0); cycle();

    // Stall alone holds; redirect with misaligned BR target beats stall
    idle(1'b1); cycle();
    drive(1, 0, 0, 0, 1, 0, 64'h0, 64'h0, 64'h4002, 1); cycle();
    // BR outranks B; clean targets leave fault sticky
    drive(1, 0, 0, 1, 1, 0, 64'h300, 64'd1, 64'h5000, 0); cycle();
    drive(1, 1, 0, 1, 0, 0, 64'h300, 64'd1, 64'h0, 0); cycle();
    idle(1'b0); cycle();

    // PC wrap at the top of the address space
    drive(1, 0, 0, 0, 1, 0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0); cycle();
    idle(1'b0); cycle();
    drive(1, 0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 64'h0, 0); cycle();

    // Async reset landing mid-cycle during a taken redirect
    drive(1, 0, 0, 1, 0, 0, 64'h8000, 64'd4, 64'h0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("async");
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0); cycle();

    // Saturation: 5 taken branches with 2-bit counters
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 0, 0, 64'h2000 + 64'(i) * 64'h40, 64'd2, 64'h0, 0); cycle();
    end
    chk("sat_bcnt", 64'(bcnt), 64'd3);
    chk("sat_tcnt", 64'(tcnt), 64'd3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [63:0] rpc, imm, rt;
      logic [31:0] r;
      if ($urandom_range(0, 63) == 0) do_reset();
      r   = $urandom;
      rpc = {$urandom, $urandom};
      imm = {{32{r[31]}}, r};
      if ($urandom_range(0, 1) == 0) imm = 64'($signed($urandom_range(0, 64)) - 32);
      rt  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
            rpc, imm, rt, $urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
